mbus_interject_monitor: RTL and testbench

Receive-side companion to the MBus error/interjection generator. It oversamples the MBus CIN/DIN lines on a local system clock, tracks a transaction from start, detects an interjection (DIN toggling while CIN is held high), then captures the two control bits that follow. Each completed interjection is reported as a single-cycle event carrying the control bits and the pre-interjection data-bit count. It sits in regression/debug fabric next to the generator, so benches and the host can confirm that injected errors are seen on the wire.

---
 rtl/mbus_mon_pkg.sv | 16 +
 rtl/mbus_edge_sync.sv | 31 +++
 rtl/mbus_interject_monitor.sv | 126 ++++++++++++
 tb/tb_mbus_interject_monitor.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mbus_mon_pkg.sv
// Shared types for the MBus interjection monitor.
// Holds the FSM state encoding and default toggle threshold.
package mbus_mon_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACTIVE = 3'd1,
    INTERJ = 3'd2,
    CTRL0  = 3'd3,
    CTRL1  = 3'd4,
    REPORT = 3'd5
  } mon_state_t;

  localparam int TOGGLE_MIN_DEF = 3;

endpackage

// File: rtl/mbus_edge_sync.sv
// Synchronizer chain plus one-cycle edge detector for an async
// MBus line; level/rise/fall are all in the CLK domain.
module mbus_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/mbus_interject_monitor.sv
// Oversampling MBus monitor: tracks a transaction, detects an
// interjection, captures two control bits and reports an event.
module mbus_interject_monitor
  import mbus_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TOGGLE_MIN  = TOGGLE_MIN_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             CIN,
  input  logic             DIN,
  output logic             EVT_VALID,
  output logic [1:0]       EVT_CTRL,
  output logic [CNT_W-1:0] EVT_BITS,
  output logic [CNT_W-1:0] EVT_COUNT,
  output logic             BUSY
);

  localparam int TW = $clog2(TOGGLE_MIN + 1);

  logic c_lvl, c_rise, c_fall;
  logic d_lvl, d_rise, d_fall;
  logic d_edge, d_tog;

  mon_state_t       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bits_shadow;
  logic [TW-1:0]    tog_cnt;
  logic             cb0;

  mbus_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cin_sync (
    .clk   (CLK),
    .rst   (RESET),
    .din   (CIN),
    .level (c_lvl),
    .rise  (c_rise),
    .fall  (c_fall)
  );

  mbus_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_din_sync (
    .clk   (CLK),
    .rst   (RESET),
    .din   (DIN),
    .level (d_lvl),
    .rise  (d_rise),
    .fall  (d_fall)
  );

  // A DIN edge coinciding with a CIN rise is a data bit, not a toggle
  assign d_edge = d_rise | d_fall;
  assign d_tog  = d_edge & c_lvl & ~c_rise;
  assign BUSY   = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tog_cnt     <= '0;
      bits_shadow <= '0;
      cb0         <= 1'b0;
      EVT_VALID   <= 1'b0;
      EVT_CTRL    <= '0;
      EVT_BITS    <= '0;
      EVT_COUNT   <= '0;
    end else if (!ENABLE) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      tog_cnt   <= '0;
      EVT_VALID <= 1'b0;
    end else begin
      EVT_VALID <= 1'b0;
      unique case (state)
        IDLE: begin
          bit_cnt <= '0;
          tog_cnt <= '0;
          if (c_lvl && d_fall)
            state <= ACTIVE;
        end
        ACTIVE: begin
          if (c_rise && bit_cnt != '1)
            bit_cnt <= bit_cnt + CNT_W'(1);
          if (c_fall) begin
            tog_cnt <= '0;
          end else if (d_tog) begin
            if (tog_cnt == TW'(TOGGLE_MIN - 1)) begin
              bits_shadow <= bit_cnt;
              state       <= INTERJ;
            end else begin
              tog_cnt <= tog_cnt + TW'(1);
            end
          end
        end
        INTERJ: begin
          if (c_fall)
            state <= CTRL0;
        end
        CTRL0: begin
          if (c_rise) begin
            cb0   <= d_lvl;
            state <= CTRL1;
          end
        end
        CTRL1: begin
          if (c_rise) begin
            EVT_VALID <= 1'b1;
            EVT_CTRL  <= {d_lvl, cb0};
            EVT_BITS  <= bits_shadow;
            if (EVT_COUNT != '1)
              EVT_COUNT <= EVT_COUNT + CNT_W'(1);
            state <= REPORT;
          end
        end
        REPORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbus_interject_monitor.sv
// Randomized bench for the MBus interjection monitor, checked
// against a transaction-level expectation model.
module tb_mbus_interject_monitor;

  localparam int SYNC = 2;
  localparam int CW   = 4;
  localparam int PH   = 6;
  localparam int MAXV = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RESET, ENABLE, CIN, DIN;
  logic          EVT_VALID, BUSY;
  logic [1:0]    EVT_CTRL;
  logic [CW-1:0] EVT_BITS, EVT_COUNT;

  int n_pass = 0;
  int n_chk  = 0;
  int pulses = 0;

  int m_count  = 0;
  int m_ctrl   = 0;
  int m_bits   = 0;
  int m_events = 0;

  mbus_interject_monitor #(
    .SYNC_STAGES (SYNC),
    .TOGGLE_MIN  (3),
    .CNT_W       (CW)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ENABLE    (ENABLE),
    .CIN       (CIN),
    .DIN       (DIN),
    .EVT_VALID (EVT_VALID),
    .EVT_CTRL  (EVT_CTRL),
    .EVT_BITS  (EVT_BITS),
    .EVT_COUNT (EVT_COUNT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (EVT_VALID === 1'b1) pulses++;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wt(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic cyc(bit dbit);
    CIN = 1'b0; wt(2);
    DIN = dbit; wt(PH - 2);
    CIN = 1'b1; wt(PH);
  endtask

  task automatic tog();
    DIN = ~DIN; wt(PH);
  endtask

  task automatic chk_outs(string tag);
    chk({tag, "_ctrl"}, int'(EVT_CTRL), m_ctrl);
    chk({tag, "_bits"}, int'(EVT_BITS), m_bits);
    chk({tag, "_count"}, int'(EVT_COUNT), m_count);
  endtask

  // mode 0: normal, 1: ENABLE drop in CTRL0, 2: RESET in INTERJ
  task automatic xact(int nclk, int ntog, bit cb0, bit cb1,
                      int mode, string tag);
    bit exp_v;
    DIN = 1'b0; wt(PH);
    for (int i = 0; i < nclk; i++) cyc(1'($urandom_range(0, 1)));
    for (int i = 0; i < ntog; i++) tog();
    if (mode == 2) begin
      chk({tag, "_busy_interj"}, int'(BUSY), 1);
      RESET = 1'b1; wt(1);
      m_count = 0; m_ctrl = 0; m_bits = 0;
      chk({tag, "_rst_valid"}, int'(EVT_VALID), 0);
      chk({tag, "_rst_busy"}, int'(BUSY), 0);
      chk_outs({tag, "_rst"});
      RESET = 1'b0;
    end
    CIN = 1'b0; wt(2);
    DIN = cb0; wt(2);
    if (mode == 1) begin
      ENABLE = 1'b0; wt(1);
      chk({tag, "_en_busy"}, int'(BUSY), 0);
      wt(1);
      ENABLE = 1'b1;
    end else begin
      wt(2);
    end
    CIN = 1'b1; wt(PH);
    CIN = 1'b0; wt(2);
    DIN = cb1; wt(PH - 2);
    CIN = 1'b1; wt(SYNC + 1);
    exp_v = (mode == 0);
    if (exp_v) begin
      m_count  = (m_count == MAXV) ? MAXV : m_count + 1;
      m_ctrl   = {cb1, cb0};
      m_bits   = (nclk > MAXV) ? MAXV : nclk;
      m_events++;
    end
    chk({tag, "_valid"}, int'(EVT_VALID), int'(exp_v));
    chk_outs(tag);
    wt(1);
    chk({tag, "_valid_off"}, int'(EVT_VALID), 0);
    wt(PH - 4);
    DIN = 1'b1; wt(PH);
    chk({tag, "_idle"}, int'(BUSY), 0);
  endtask

  task automatic incomplete();
    DIN = 1'b0; wt(PH);
    cyc(1'b1); cyc(1'b0);
    tog(); tog();
    cyc(1'b0);
    tog(); tog();
    cyc(1'b1); cyc(1'b0); cyc(1'b1);
    wt(PH);
    chk("inc_busy", int'(BUSY), 1);
    chk("inc_pulses", pulses, m_events);
    chk("inc_count", int'(EVT_COUNT), m_count);
    ENABLE = 1'b0; wt(2);
    ENABLE = 1'b1; wt(1);
    chk("inc_dis_busy", int'(BUSY), 0);
    DIN = 1'b1; wt(PH);
  endtask

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; CIN = 1'b1; DIN = 1'b1;
    wt(3);
    chk("rst_valid", int'(EVT_VALID), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk_outs("rst");
    RESET = 1'b0;
    wt(PH);

    xact(5, 3, 1'b0, 1'b1, 0, "basic");
    incomplete();
    xact(2, 3, 1'b1, 1'b1, 0, "seq_a");
    wt(3 * PH);
    xact(7, 4, 1'b1, 1'b0, 0, "seq_b");
    xact(4, 3, 1'b1, 1'b0, 1, "en_drop");
    xact(3, 3, 1'b0, 1'b1, 0, "after_en");
    xact(6, 3, 1'b1, 1'b1, 2, "rst_mid");
    xact(18, 3, 1'b0, 1'b0, 0, "bit_sat");

    for (int k = 0; k < 30; k++) begin
      xact($urandom_range(0, 20), $urandom_range(3, 5),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0) ? 1 : 0, "rnd");
    end

    chk("pulses_total", pulses, m_events);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
